// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA timing controller.
package dma_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = $clog2(NUM_CH);

  typedef logic [2:0] state_t;

  localparam state_t StSi = 3'd0;
  localparam state_t StS0 = 3'd1;
  localparam state_t StS1 = 3'd2;
  localparam state_t StS2 = 3'd3;
  localparam state_t StS3 = 3'd4;
  localparam state_t StS4 = 3'd5;

  typedef enum logic [1:0] {
    XferDemand = 2'b00,
    XferSingle = 2'b01,
    XferBlock  = 2'b10,
    XferRsvd   = 2'b11
  } xfer_mode_t;

  typedef enum logic [1:0] {
    TypeVerify  = 2'b00,
    TypeWrite   = 2'b01,
    TypeRead    = 2'b10,
    TypeIllegal = 2'b11
  } xfer_type_t;

endpackage

// File: rtl/dma_strobe_decode.sv
// Combinational map from {state, transfer type} to the four active-low command strobes.
module dma_strobe_decode
  import dma_pkg::*;
(
  input  logic [2:0] state_i,
  input  logic [1:0] type_i,
  output logic       mem_r_no,
  output logic       mem_w_no,
  output logic       io_r_no,
  output logic       io_w_no
);

  logic rd_phase;
  logic wr_phase;

  always_comb begin
    rd_phase = (state_i == StS2) || (state_i == StS3);
    wr_phase = (state_i == StS3);
    mem_r_no = 1'b1;
    mem_w_no = 1'b1;
    io_r_no  = 1'b1;
    io_w_no  = 1'b1;
    // Verify and illegal types run the bus cycle with no command strobes.
    case (xfer_type_t'(type_i))
      TypeWrite: begin
        io_r_no  = ~rd_phase;
        mem_w_no = ~wr_phase;
      end
      TypeRead: begin
        mem_r_no = ~rd_phase;
        io_w_no  = ~wr_phase;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dma_timing_control.sv
// 8237A-style DMA bus-cycle sequencer: hold handshake, address strobes, command strobes and
// single/block/demand transfer termination for the channel granted by the priority encoder.
module dma_timing_control
  import dma_pkg::*;
#(
  parameter int unsigned NumCh = NUM_CH,
  parameter int unsigned ChW   = CH_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_req_id_i,
  input  logic [ChW-1:0]     req_id_i,
  input  logic [NumCh-1:0]   pending_req_i,
  input  logic               hlda_i,
  input  logic               ready_i,
  input  logic               eop_in_ni,
  input  logic               tc_in_i,
  input  logic [2*NumCh-1:0] ch_mode_i,
  input  logic [2*NumCh-1:0] ch_type_i,
  output logic               hrq_o,
  output logic               aen_o,
  output logic               adstb_o,
  output logic               mem_r_no,
  output logic               mem_w_no,
  output logic               io_r_no,
  output logic               io_w_no,
  output logic               eop_out_no,
  output logic               dec_count_o,
  output logic [NumCh-1:0]   tc_status_o,
  output logic               busy_o
);

  logic [2:0]     state_q, state_d;
  logic [ChW-1:0] act_ch_q, act_ch_d;
  logic [1:0]     act_mode_q, act_mode_d;
  logic [1:0]     act_type_q, act_type_d;
  logic           term_q, term_d;
  logic           tc_q, tc_d;
  logic           mem_r_q, mem_w_q, io_r_q, io_w_q;
  logic           mem_r_d, mem_w_d, io_r_d, io_w_d;

  logic in_cycle;
  logic hlda_lost;
  logic term_now;

  assign in_cycle  = (state_q == StS1) || (state_q == StS2) ||
                     (state_q == StS3) || (state_q == StS4);
  assign hlda_lost = in_cycle && !hlda_i;
  assign term_now  = (state_q == StS4) && hlda_i && (term_q || !eop_in_ni);

  always_comb begin
    state_d    = state_q;
    act_ch_d   = act_ch_q;
    act_mode_d = act_mode_q;
    act_type_d = act_type_q;
    term_d     = term_q;
    tc_d       = tc_q;
    case (state_q)
      StSi: begin
        // Hlda must be seen low first so the previous owner's hold is fully released.
        if (valid_req_id_i && !hlda_i) begin
          state_d    = StS0;
          act_ch_d   = req_id_i;
          act_mode_d = ch_mode_i[{req_id_i, 1'b0} +: 2];
          act_type_d = ch_type_i[{req_id_i, 1'b0} +: 2];
        end
      end
      StS0: if (hlda_i) state_d = StS1;
      StS1: state_d = StS2;
      StS2: state_d = StS3;
      StS3: begin
        if (!eop_in_ni || tc_in_i) term_d = 1'b1;
        if (tc_in_i) tc_d = 1'b1;
        if (ready_i) state_d = StS4;
      end
      StS4: begin
        if (term_q || !eop_in_ni) begin
          state_d = StSi;
          term_d  = 1'b0;
          tc_d    = 1'b0;
        end else begin
          unique case (xfer_mode_t'(act_mode_q))
            XferBlock:  state_d = StS1;
            XferDemand: state_d = pending_req_i[act_ch_q] ? StS1 : StSi;
            XferSingle: state_d = StSi;
            XferRsvd:   state_d = StSi;
          endcase
        end
      end
      default: state_d = StSi;
    endcase
    if (hlda_lost) begin
      state_d = StSi;
      term_d  = 1'b0;
      tc_d    = 1'b0;
    end
  end

  dma_strobe_decode u_strobe_decode (
    .state_i  (state_d),
    .type_i   (act_type_q),
    .mem_r_no (mem_r_d),
    .mem_w_no (mem_w_d),
    .io_r_no  (io_r_d),
    .io_w_no  (io_w_d)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StSi;
      act_ch_q   <= '0;
      act_mode_q <= '0;
      act_type_q <= '0;
      term_q     <= 1'b0;
      tc_q       <= 1'b0;
      mem_r_q    <= 1'b1;
      mem_w_q    <= 1'b1;
      io_r_q     <= 1'b1;
      io_w_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      act_ch_q   <= act_ch_d;
      act_mode_q <= act_mode_d;
      act_type_q <= act_type_d;
      term_q     <= term_d;
      tc_q       <= tc_d;
      mem_r_q    <= mem_r_d;
      mem_w_q    <= mem_w_d;
      io_r_q     <= io_r_d;
      io_w_q     <= io_w_d;
    end
  end

  always_comb begin
    hrq_o       = (state_q != StSi);
    busy_o      = (state_q != StSi);
    aen_o       = in_cycle;
    adstb_o     = (state_q == StS1);
    dec_count_o = (state_q == StS4) && hlda_i;
    eop_out_no  = !(term_now && tc_q);
    tc_status_o = '0;
    if (term_now) tc_status_o[act_ch_q] = 1'b1;
  end

  assign mem_r_no = mem_r_q;
  assign mem_w_no = mem_w_q;
  assign io_r_no  = io_r_q;
  assign io_w_no  = io_w_q;

endmodule
